// File: rtl/inst_fetch.sv
// inst_fetch -- RV32I instruction-fetch stage.
//
// Holds the PC, issues one word read at a time to instruction memory over a
// req/ack handshake, registers the returned word and presents it with its PC
// to the control unit. When the control unit retires the instruction
// (inst_ready), the next PC is PC+4 or the ALU target, chosen by PCSel.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   PCSel        1 = next PC is alu_target, 0 = PC+4 (sampled at retire only)
//   alu_target   branch/jump target from the ALU
//   inst_ready   downstream has executed the presented instruction
//   imem_req     instruction-memory read request
//   imem_addr    word-aligned read address (equal to pc)
//   imem_ack     read data valid this cycle (honoured only while fetching)
//   imem_rdata   read data
//   inst, pc     registered instruction and its address
//   inst_valid   inst/pc are valid
//   misalign     sticky: some redirect target had bits [1:0] != 0
//   retire_cnt   number of retired instructions (wraps)
module inst_fetch #(
    parameter int unsigned           INST_LENGTH = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned           CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PCSel,
    input  logic [ADDR_WIDTH-1:0]  alu_target,
    input  logic                   inst_ready,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INST_LENGTH-1:0] imem_rdata,
    output logic [INST_LENGTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   inst_valid,
    output logic                   misalign,
    output logic [CNT_WIDTH-1:0]   retire_cnt
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [INST_LENGTH-1:0] NOP_INST = INST_LENGTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0]  PC_STEP  = ADDR_WIDTH'(32'd4);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(32'd1);

    logic [1:0]             state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_nxt_s, next_pc_s;
    logic [INST_LENGTH-1:0] inst_r, inst_nxt_s;
    logic                   inst_valid_r, inst_valid_nxt_s;
    logic                   imem_req_r, imem_req_nxt_s;
    logic                   misalign_r, misalign_nxt_s;
    logic [CNT_WIDTH-1:0]   retire_cnt_r, retire_cnt_nxt_s;
    logic                   target_misaligned_s;

    // Candidate next PC; the low two target bits are dropped to keep fetches word aligned.
    always_comb begin
        target_misaligned_s = (alu_target[1:0] != 2'b00);
        if (PCSel) begin
            next_pc_s = {alu_target[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        inst_nxt_s       = inst_r;
        inst_valid_nxt_s = inst_valid_r;
        imem_req_nxt_s   = imem_req_r;
        misalign_nxt_s   = misalign_r;
        retire_cnt_nxt_s = retire_cnt_r;
        case (state_r)
            ST_BOOT: begin
                // One idle cycle after reset, then start the first fetch.
                state_nxt_s    = ST_FETCH;
                imem_req_nxt_s = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_nxt_s       = imem_rdata;
                    inst_valid_nxt_s = 1'b1;
                    imem_req_nxt_s   = 1'b0;
                    state_nxt_s      = ST_EXEC;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // A stray imem_ack here is deliberately ignored.
                if (inst_ready) begin
                    pc_nxt_s         = next_pc_s;
                    inst_valid_nxt_s = 1'b0;
                    imem_req_nxt_s   = 1'b1;
                    retire_cnt_nxt_s = retire_cnt_r + CNT_ONE;
                    misalign_nxt_s   = misalign_r | (PCSel & target_misaligned_s);
                    state_nxt_s      = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            default: begin
                // Unreachable encoding: drop any presented instruction and reboot.
                state_nxt_s      = ST_BOOT;
                inst_valid_nxt_s = 1'b0;
                imem_req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forgets any outstanding response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_INST;
            inst_valid_r <= 1'b0;
            imem_req_r   <= 1'b0;
            misalign_r   <= 1'b0;
            retire_cnt_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            inst_r       <= inst_nxt_s;
            inst_valid_r <= inst_valid_nxt_s;
            imem_req_r   <= imem_req_nxt_s;
            misalign_r   <= misalign_nxt_s;
            retire_cnt_r <= retire_cnt_nxt_s;
        end
    end

    // The read address is the PC register itself, so it cannot move during a fetch.
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign inst       = inst_r;
    assign inst_valid = inst_valid_r;
    assign imem_req   = imem_req_r;
    assign misalign   = misalign_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed self-checking bench for inst_fetch.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        PCSel;
    logic [31:0] alu_target;
    logic        inst_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        misalign;
    logic [31:0] retire_cnt;

    int unsigned vec_cnt;
    int unsigned miscompare_cnt;
    logic [31:0] exp_cnt;
    logic        exp_mis;

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSel      (PCSel),
        .alu_target (alu_target),
        .inst_ready (inst_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .misalign   (misalign),
        .retire_cnt (retire_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Check every output against its reset value.
    task automatic check_reset(input string tag);
        check_vec({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check_vec({tag, "_addr"},  imem_addr,           32'h0000_0000);
        check_vec({tag, "_pc"},    pc,                  32'h0000_0000);
        check_vec({tag, "_inst"},  inst,                32'h0000_0013);
        check_vec({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check_vec({tag, "_mis"},   {31'd0, misalign},   32'd0);
        check_vec({tag, "_cnt"},   retire_cnt,          32'd0);
    endtask

    // One full instruction: entered and left at a falling edge in FETCH.
    task automatic run_instr(input int ack_dly, input int rdy_dly, input logic sel,
                             input logic [31:0] tgt, input logic [31:0] exp_pc,
                             input logic [31:0] exp_next, input logic stray);
        logic [31:0] word;
        word = exp_pc ^ 32'hA5A5_A5A5;
        // inst_ready high and junk redirect inputs during FETCH must be ignored.
        inst_ready = 1'b1;
        PCSel      = ~sel;
        alu_target = 32'hDEAD_BEE1;
        check_vec("fetch_req",  {31'd0, imem_req}, 32'd1);
        check_vec("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check_vec("addr_stable", imem_addr, exp_pc);
            check_vec("req_held", {31'd0, imem_req}, 32'd1);
            check_vec("no_valid_in_fetch", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        if (rdy_dly == 0) begin
            PCSel      = sel;
            alu_target = tgt;
        end else begin
            inst_ready = 1'b0;
        end
        @(negedge clk);
        imem_ack   = stray;
        imem_rdata = stray ? 32'hBAD0_BAD0 : 32'h0000_0000;
        check_vec("exec_valid", {31'd0, inst_valid}, 32'd1);
        check_vec("exec_inst",  inst, word);
        check_vec("exec_pc",    pc, exp_pc);
        check_vec("exec_req",   {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            check_vec("inst_stable",  inst, word);
            check_vec("pc_stable",    pc, exp_pc);
            check_vec("valid_held",   {31'd0, inst_valid}, 32'd1);
            check_vec("no_second_req", {31'd0, imem_req}, 32'd0);
        end
        if (rdy_dly != 0) begin
            inst_ready = 1'b1;
            PCSel      = sel;
            alu_target = tgt;
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        if (sel && (tgt[1:0] != 2'b00)) exp_mis = 1'b1;
        check_vec("retire_req",   {31'd0, imem_req}, 32'd1);
        check_vec("retire_addr",  imem_addr, exp_next);
        check_vec("retire_pc",    pc, exp_next);
        check_vec("retire_valid", {31'd0, inst_valid}, 32'd0);
        check_vec("retire_cnt",   retire_cnt, exp_cnt);
        check_vec("misalign",     {31'd0, misalign}, {31'd0, exp_mis});
        PCSel      = ~sel;
        alu_target = 32'hDEAD_BEE1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        exp_cnt        = 32'd0;
        exp_mis        = 1'b0;
        rst_n          = 1'b0;
        PCSel          = 1'b0;
        alu_target     = 32'h0000_0000;
        inst_ready     = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0000_0000;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("rst_hold");
        end
        rst_n = 1'b1;
        #1;
        check_vec("boot_idle", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Sequential zero-wait fetches: 0, 4, 8, 12.
        run_instr(0, 0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0008, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_000C, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 32'h0000_000C, 32'h0000_0010, 1'b0);
        check_vec("cnt_after_4", retire_cnt, 32'd4);

        // Wait states and backpressure.
        run_instr(3, 2, 1'b0, 32'h0, 32'h0000_0010, 32'h0000_0014, 1'b0);

        // Redirects, aligned then misaligned.
        run_instr(0, 0, 1'b1, 32'h0000_0040, 32'h0000_0014, 32'h0000_0040, 1'b0);
        run_instr(1, 1, 1'b1, 32'h0000_0100, 32'h0000_0040, 32'h0000_0100, 1'b0);
        run_instr(0, 1, 1'b1, 32'h0000_0203, 32'h0000_0100, 32'h0000_0200, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0000_0003, 32'h0000_0200, 32'h0000_0204, 1'b0);

        // PC wrap with a stray ack during EXEC.
        run_instr(0, 0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0204, 32'hFFFF_FFFC, 1'b0);
        run_instr(0, 2, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        run_instr(0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 1'b0);

        // Reset mid-fetch with an ack arriving around the reset.
        imem_ack = 1'b0;
        @(negedge clk);
        check_vec("pending_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFEED_FACE;
        #1;
        check_reset("rst_async");
        @(negedge clk);
        check_reset("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("late_ack_valid", {31'd0, inst_valid}, 32'd0);
        check_vec("late_ack_inst",  inst, 32'h0000_0013);
        imem_ack = 1'b0;
        exp_cnt  = 32'd0;
        exp_mis  = 1'b0;
        run_instr(0, 0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
